// File: rtl/enigma_pkg.sv
// enigma_pkg: shared alphabet constants, FSM states, mod-26 helpers and table unpacking
package enigma_pkg;
  localparam int ALPHA = 26;
  localparam logic [7:0] ASCII_A = 8'd65;
  typedef enum logic [1:0] {IDLE, MAP, OUT, BUILD} state_t;
  function automatic logic is_letter(input logic [7:0] c);
    return c >= ASCII_A && c <= 8'd90;
  endfunction
  function automatic logic [4:0] to_idx(input logic [7:0] c);
    return 5'(c - ASCII_A);
  endfunction
  function automatic logic [4:0] add26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction
  function automatic logic [4:0] sub26(input logic [4:0] a, input logic [4:0] b);
    return add26(a, 5'(6'd26 - {1'b0, b}));
  endfunction
  function automatic logic [7:0] tbl_slice(input logic [207:0] v, input int i);
    return v[200-8*i +: 8];
  endfunction
endpackage

// File: rtl/rotor_inv_builder.sv
// rotor_inv_builder: walks the wiring table one entry per cycle and fills the inverse table
module rotor_inv_builder
  import enigma_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tbl [ALPHA],
  output logic [4:0] inv [ALPHA],
  output logic       done
);
  logic [4:0] k;
  logic       busy;
  logic [7:0] e;
  assign e = tbl[k];
  assign done = busy && k == 5'd25;
  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      k <= '0;
      for (int i = 0; i < ALPHA; i++) inv[i] <= '0;
    end else if (start) begin
      busy <= 1'b1;
      k <= '0;
    end else if (busy) begin
      if (is_letter(e)) inv[to_idx(e)] <= k;
      busy <= k != 5'd25;
      k <= (k == 5'd25) ? 5'd0 : k + 5'd1;
    end
  end
endmodule

// File: rtl/enigma_rotor.sv
// enigma_rotor: one rotor stage with forward/inverse wiring, stepping and notch carry.
// Define ENIGMA_DOUBLE_STEP_EN to enable the middle-rotor self-step on forward letters.
module enigma_rotor
  import enigma_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         set,
  input  logic [207:0] idx_in,
  input  logic [7:0]   pos_in,
  input  logic [7:0]   notch_in,
  input  logic         valid_in,
  input  logic [7:0]   din,
  input  logic         dir,
  input  logic         step_in,
  output logic         ready,
  output logic [7:0]   dout,
  output logic         done,
  output logic         step_out,
  output logic [7:0]   pos_out
);
  state_t     state, state_nx;
  logic [7:0] tbl [ALPHA];
  logic [4:0] inv [ALPHA];
  logic [4:0] pos, pos_nx, notch, p_q, x_q, y;
  logic [7:0] din_q, res;
  logic       dir_q, loaded, build_done, accept, step, ds;
  rotor_inv_builder u_inv (
    .clk   (clk),
    .reset (reset),
    .start (set),
    .tbl   (tbl),
    .inv   (inv),
    .done  (build_done)
  );
  assign ready = loaded && state == IDLE;
  assign pos_out = ASCII_A + {3'b0, pos};
`ifdef ENIGMA_DOUBLE_STEP_EN
  assign ds = accept && !dir && is_letter(din) && pos == sub26(notch, 5'd1);
`else
  assign ds = 1'b0;
`endif
  always_comb begin
    accept = valid_in && ready && !set;
    step = (step_in || ds) && state != BUILD && !set;
    pos_nx = step ? ((pos == 5'd25) ? 5'd0 : pos + 5'd1) : pos;
    state_nx = set ? BUILD :
               (state == IDLE && accept) ? MAP :
               state == MAP ? OUT :
               state == OUT ? IDLE :
               (state == BUILD && build_done) ? IDLE : state;
    y = dir_q ? inv[x_q] : to_idx(tbl[x_q]);
    res = is_letter(din_q) ? ASCII_A + {3'b0, sub26(y, p_q)} : din_q;
  end
  // a character keeps the position it was accepted with, even if stepping continues in MAP
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      for (int i = 0; i < ALPHA; i++) tbl[i] <= '0;
      pos <= '0;
      notch <= '0;
      p_q <= '0;
      x_q <= '0;
      din_q <= '0;
      dir_q <= 1'b0;
      dout <= '0;
      done <= 1'b0;
      step_out <= 1'b0;
      loaded <= 1'b0;
    end else begin
      state <= state_nx;
      pos <= set ? to_idx(pos_in) : pos_nx;
      step_out <= step && (ds || pos == notch);
      done <= state == MAP && !set;
      if (set) begin
        notch <= to_idx(notch_in);
        for (int i = 0; i < ALPHA; i++) tbl[i] <= tbl_slice(idx_in, i);
      end
      if (accept) begin
        x_q <= is_letter(din) ? add26(to_idx(din), pos_nx) : 5'd0;
        p_q <= pos_nx;
        din_q <= din;
        dir_q <= dir;
      end
      if (state == MAP && !set) dout <= res;
      if (state == BUILD && build_done) loaded <= 1'b1;
    end
  end
endmodule

// File: tb/tb_enigma_rotor.sv
// tb_enigma_rotor: directed scoreboard bench for enigma_rotor with an independent % 26 model
module tb_enigma_rotor;
  logic         clk = 0, reset = 1, set = 0, valid_in = 0, dir = 0, step_in = 0;
  logic [207:0] idx_in = '0;
  logic [7:0]   pos_in = 0, notch_in = 0, din = 0;
  logic         ready, done, step_out;
  logic [7:0]   dout, pos_out;
  int checks = 0, errors = 0, cyc = 0;
  string rotor_i = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  typedef struct { logic [7:0] v; int c; } exp_t;
  exp_t sb[$];

  enigma_rotor dut (
    .clk(clk), .reset(reset), .set(set), .idx_in(idx_in), .pos_in(pos_in),
    .notch_in(notch_in), .valid_in(valid_in), .din(din), .dir(dir), .step_in(step_in),
    .ready(ready), .dout(dout), .done(done), .step_out(step_out), .pos_out(pos_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && done) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_done: observed dout %0d with nothing expected", dout);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("dout", dout, e.v);
        chk("latency_cycle", 8'(cyc), 8'(e.c));
      end
    end
  end

  function automatic logic [7:0] model(input logic [7:0] c, input bit rev, input int p);
    int x, y;
    if (c < 65 || c > 90) return c;
    x = (int'(c) - 65 + p) % 26;
    y = 0;
    if (!rev) y = int'(rotor_i[x]) - 65;
    else for (int i = 0; i < 26; i++) if (int'(rotor_i[i]) - 65 == x) y = i;
    return 8'((y - p + 26) % 26 + 65);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin tick(); n++; end
    chk(tag, 8'(n), 8'd26);
  endtask

  task automatic load(input logic [7:0] p, input logic [7:0] nt);
    for (int i = 0; i < 26; i++) idx_in[200-8*i +: 8] = rotor_i[i];
    pos_in = p; notch_in = nt; set = 1;
    tick();
    set = 0;
    wait_ready("build_len");
    chk("pos_after_load", pos_out, p);
  endtask

  task automatic send(input logic [7:0] c, input logic d, input logic st, input logic [7:0] exp);
    int n;
    chk("ready_before_send", 8'(ready), 8'd1);
    valid_in = 1; din = c; dir = d; step_in = st;
    sb.push_back('{exp, cyc + 2});
    tick();
    valid_in = 0; step_in = 0;
    n = 0;
    while (sb.size() != 0 && n < 8) begin tick(); n++; end
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL done_timeout: observed %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [7:0] f;
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_ready", 8'(ready), 8'd0);
    chk("rst_done", 8'(done), 8'd0);
    chk("rst_step_out", 8'(step_out), 8'd0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_pos_out", pos_out, "A");
    // rotor I at position A, notch Q
    load("A", "Q");
    send("A", 0, 0, "E");
    send("E", 1, 0, "A");
    send("K", 1, 0, "B");
    for (int i = 0; i < 26; i++) begin
      f = model(8'(65 + i), 0, 0);
      send(8'(65 + i), 0, 0, f);
      send(f, 1, 0, 8'(65 + i));
    end
    // stepping alone, then stepping together with a letter
    step_in = 1;
    tick();
    step_in = 0;
    chk("step_pos_B", pos_out, "B");
    send("A", 0, 0, "J");
    send("J", 1, 0, "A");
    load("A", "Q");
    send("A", 0, 1, "J");
    chk("step_with_valid_pos", pos_out, "B");
    // notch carry and wrap
    load("Q", "Q");
    step_in = 1;
    tick();
    step_in = 0;
    chk("notch_pos_R", pos_out, "R");
    chk("notch_carry", 8'(step_out), 8'd1);
    tick();
    chk("notch_carry_one_cycle", 8'(step_out), 8'd0);
    send("A", 0, 0, model("A", 0, 17));
    send("M", 1, 0, model("M", 1, 17));
    load("Z", "Q");
    send("C", 0, 0, model("C", 0, 25));
    step_in = 1;
    tick();
    step_in = 0;
    chk("wrap_pos_A", pos_out, "A");
    chk("wrap_no_carry", 8'(step_out), 8'd0);
    // set while a character is in MAP aborts it; valid_in ignored during BUILD
    load("D", "Q");
    valid_in = 1; din = "A"; dir = 0;
    tick();
    set = 1;
    tick();
    set = 0;
    wait_ready("abort_build_len");
    valid_in = 0;
    repeat (4) tick();
    chk("abort_dout_held", dout, model("C", 0, 25));
    send("A", 0, 0, model("A", 0, 3));
    // non-letter pass-through
    send("5", 0, 0, "5");
    send("a", 1, 0, "a");
    // reset in the middle of a build
    set = 1;
    tick();
    set = 0;
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    chk("midbuild_ready", 8'(ready), 8'd0);
    chk("midbuild_dout", dout, 8'h00);
    chk("midbuild_done", 8'(done), 8'd0);
    chk("midbuild_step_out", 8'(step_out), 8'd0);
    chk("midbuild_pos_out", pos_out, "A");
    repeat (30) tick();
    chk("midbuild_still_unloaded", 8'(ready), 8'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
